uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial-to-parallel 8N1 UART receiver feeding uart_top's receive path.
//  Synchronises the asynchronous rx pin and confirms the start bit at mid-bit.
//  Samples 8 data bits LSB first, then checks the stop bit.
//  Presents the byte with a 1-cycle valid pulse; flags framing errors. uart_top drives LED6 from i_en/o_busy.
// PARAMETERS
//  CLK_FREQ_HZ   125_000_000  system clock frequency (Zybo Z7-20 sysclk)
//  BAUD_RATE     115_200      line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer divide, 1085 @ defaults)
// PORTS
//  sysclk       in   1  system clock, all logic on rising edge
//  rst          in   1  synchronous, active-high reset
//  i_en         in   1  receiver enable (btn[1]/BTN3 path); low forces IDLE
//  i_rx         in   1  asynchronous serial line, idle high
//  o_data       out  8  last correctly framed byte, bit0 = first data bit received
//  o_valid      out  1  1-cycle pulse: o_data updated this cycle
//  o_frame_err  out  1  1-cycle pulse: stop bit sampled low, byte discarded
//  o_busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset: sync flops = 1, state = IDLE, counters = 0, o_data = 8'h00, o_valid/o_frame_err/o_busy = 0.
//  rx_s: i_rx after 2-flop synchroniser (2-cycle latency); all decisions use rx_s only.
//  Baud counter: counts 0..CLKS_PER_BIT-1; bit index 0..7 (3 bits).
//  FSM:
//   IDLE : busy=0; if i_en && rx_s==0 -> START, counter=0.
//   START: when counter==CLKS_PER_BIT/2-1 (mid start bit): rx_s==0 -> DATA, counter=0, idx=0;
//          rx_s==1 -> false start, back to IDLE, no pulse.
//   DATA : when counter==CLKS_PER_BIT-1: shift rx_s into shift reg at idx (LSB first), counter=0;
//          idx==7 -> STOP, else idx+1.
//   STOP : when counter==CLKS_PER_BIT-1 (mid stop bit): rx_s==1 -> o_data<=shift reg, o_valid=1;
//          rx_s==0 -> o_frame_err=1, o_data held. Either case -> IDLE in the same edge.
//  Return to IDLE at mid stop bit permits back-to-back frames with no idle gap.
//  o_valid and o_frame_err are registered, high for exactly one cycle, and never both high.
//  Latency: first rx_s low sample to o_valid high = CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
//  i_en low in any state: next cycle state=IDLE, counters cleared, no pulse; o_data held.
//  IDLE with rx_s already low on i_en rise: treated as start edge (no falling-edge qualification).
//  rst mid-frame: all state returns to reset values on the next edge; partial byte is lost.
//  Break (line held low): one frame_err, then re-enters START repeatedly; each attempt frame_errs until line idles high.
// TESTING  (bench: CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000 -> CLKS_PER_BIT=10)
//  1. rst 2 cycles, i_en=1, i_rx=1 -> o_data=00, o_valid=0, o_frame_err=0, o_busy=0 for 50 cycles.
//  2. Send 8'hA5, stop=1 -> o_valid single pulse, o_data=A5, o_frame_err=0, o_busy low after.
//  3. Drive i_rx low 3 cycles then high -> o_busy high <=7 cycles, returns IDLE, no o_valid or o_frame_err.
//  4. Send 8'h3C with stop bit 0 after a prior A5 -> o_frame_err single pulse, o_valid=0, o_data stays A5.
//  5. Back-to-back 8'h00 then 8'hFF, no idle gap -> two o_valid pulses, 100 cycles apart, data 00 then FF.
//  6. Deassert i_en (or assert rst) during bit 4 of 8'h5A -> o_busy=0 next cycle, no pulse; next full frame 8'h81 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Synchronises the asynchronous rx line,
//                confirms the start bit at mid-bit, samples 8 data bits LSB
//                first at their centres, then checks the stop bit. A good
//                frame updates o_data with a one-cycle o_valid pulse. A low
//                stop bit gives a one-cycle o_frame_err pulse and drops the
//                byte.
//  Ports       : sysclk      in   system clock, rising edge
//                rst         in   synchronous active-high reset
//                i_en        in   receiver enable; low forces IDLE
//                i_rx        in   asynchronous serial line, idle high
//                o_data      out  last correctly framed byte (bit0 first rx)
//                o_valid     out  1-cycle pulse, o_data updated
//                o_frame_err out  1-cycle pulse, stop bit was low
//                o_busy      out  high whenever not IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Two-flop synchroniser; flops reset high so reset never looks like a start bit.
  logic sync1;
  logic rx_s;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       data_n;
  logic             valid_n;
  logic             frame_err_n;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sync1       <= i_rx;
      rx_s        <= sync1;
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      o_data      <= data_n;
      o_valid     <= valid_n;
      o_frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    data_n      = o_data;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;

    if (!i_en) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_n = '0;
          idx_n = '0;
          // Level-sensitive: a line already low when enabled counts as a start.
          if (!rx_s) state_n = START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_n = '0;
            idx_n = '0;
            state_n = rx_s ? IDLE : DATA;  // high at mid-bit: glitch, not a start
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt_n        = '0;
            shreg_n[idx] = rx_s;
            if (idx == 3'd7) state_n = STOP;
            else             idx_n   = idx + 3'd1;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        STOP: begin
          // Leaving at mid stop bit leaves half a bit of slack, so the next
          // start edge can follow the stop bit with no idle gap.
          if (cnt == BIT_LAST) begin
            cnt_n   = '0;
            state_n = IDLE;
            if (rx_s) begin
              data_n  = shreg;
              valid_n = 1'b1;
            end else begin
              frame_err_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Stimulus serialises bytes
//                onto i_rx and pushes the expected result into a queue; a
//                monitor pops and compares on every o_valid / o_frame_err.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_en;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  uart_rx #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000)
  ) dut (
    .sysclk     (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  int         vstamp[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && (o_valid || o_frame_err)) begin
      if (o_valid && o_frame_err) begin
        chk("valid_and_ferr_together", 32'd1, 32'd0);
      end else if (q.size() == 0) begin
        chk("unexpected_pulse", {o_valid, o_frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind_is_ferr", o_frame_err, e.err);
        chk("o_data", o_data, e.data);
        if (o_valid) vstamp.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic stop);
    exp_t e;
    if (stop) begin
      last_good = b;
      e.err = 1'b0;
    end else begin
      e.err = 1'b1;
    end
    e.data = last_good;
    q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      i_rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      repeat (CPB) @(negedge clk);
    end
    i_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(name, q.size(), 32'd0);
  endtask

  // Drive start + bits 0..3 + half of bit 4 of a frame, then stop.
  task automatic partial_frame(input logic [7:0] b);
    for (int i = 0; i < 5; i++) begin
      i_rx = (i == 0) ? 1'b0 : b[i-1];
      repeat (CPB) @(negedge clk);
    end
    i_rx = b[4];
    repeat (CPB / 2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    rst = 1'b1; i_en = 1'b1; i_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1. quiet line after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("reset_idle", {o_data, o_valid, o_frame_err, o_busy}, 32'd0);
    end

    // 2. one good frame
    send(8'hA5, 1'b1);
    idle(10);
    drain("a5_drain");
    chk("a5_busy_after", o_busy, 32'd0);
    chk("a5_data_held", o_data, 32'hA5);

    // 3. short glitch is rejected
    i_rx = 1'b0;
    repeat (3) @(negedge clk);
    i_rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_busy) busy_cnt++;
    end
    chk("glitch_busy_seen", (busy_cnt > 0), 32'd1);
    chk("glitch_busy_le7", (busy_cnt <= 7), 32'd1);
    chk("glitch_back_idle", o_busy, 32'd0);

    // 4. framing error keeps the previous byte
    send(8'h3C, 1'b0);
    idle(20);
    drain("ferr_drain");
    chk("ferr_data_kept", o_data, 32'hA5);

    // 5. back-to-back frames, 100 cycles apart
    vstamp.delete();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(10);
    drain("b2b_drain");
    chk("b2b_count", vstamp.size(), 32'd2);
    if (vstamp.size() == 2) chk("b2b_spacing", vstamp[1] - vstamp[0], 32'd100);

    // 6a. i_en dropped during bit 4
    partial_frame(8'h5A);
    i_en = 1'b0;
    @(negedge clk);
    chk("en_abort_busy", o_busy, 32'd0);
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
    i_en = 1'b1;
    idle(20);
    chk("en_abort_data", o_data, 32'hFF);
    send(8'h81, 1'b1);
    idle(10);
    drain("en_81_drain");

    // 6b. reset during bit 4 clears o_data
    partial_frame(8'h5A);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    chk("rst_abort_busy", o_busy, 32'd0);
    chk("rst_abort_data", o_data, 32'h00);
    idle(20);
    send(8'h81, 1'b1);
    idle(10);
    drain("rst_81_drain");

    // Random frames against the model
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic       s;
      b = 8'($urandom);
      s = ($urandom_range(0, 4) != 0);
      send(b, s);
      idle(s ? $urandom_range(0, 3) : 12);
    end
    idle(10);
    drain("random_drain");
    chk("random_final_data", o_data, {24'd0, last_good});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
